// File: rtl/systolic_feeder.sv
// systolic_feeder: streaming front-end for the N x N systolic array.
// Takes unskewed x rows / w columns on a valid/ready handshake, applies the
// per-lane diagonal skew (lane j delayed by j advances), appends zero flush
// vectors so the last products drain through the array, honours arr_stall
// and pulses done when the job is complete.
module systolic_feeder #(
    parameter int N          = 4,
    parameter int DATA_W     = 32,
    parameter int KMAX       = 256,
    parameter int PIPE_EXTRA = 3
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         start,
    input  logic [$clog2(KMAX+1)-1:0]    k_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*DATA_W-1:0]          x_row,
    input  logic [N*DATA_W-1:0]          w_col,
    output logic                         arr_start,
    output logic                         arr_valid,
    output logic [N*DATA_W-1:0]          arr_x,
    output logic [N*DATA_W-1:0]          arr_w,
    input  logic                         arr_stall,
    output logic                         busy,
    output logic                         done
);

    localparam int KW        = $clog2(KMAX + 1);
    localparam int FLUSH_LEN = N - 1 + PIPE_EXTRA;
    localparam int FW        = $clog2(FLUSH_LEN + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [KW-1:0]       k_lat;
    logic [KW-1:0]       beat_cnt;
    logic [FW-1:0]       flush_cnt;
    logic [KW-1:0]       k_clamped;
    logic                start_pend;
    logic                armed;
    logic                accept_start;
    logic                advance;
    logic                feed_src;
    logic [N*DATA_W-1:0] src_x;
    logic [N*DATA_W-1:0] src_w;

    // Oversized job lengths saturate at the largest supported reduction.
    assign k_clamped = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;

    // 'armed' is low only in the first cycle after reset release, so a start
    // coinciding with the release edge is ignored.
    assign accept_start = (state == IDLE) && start && armed;

    assign advance = arr_valid && !arr_stall;

    // Lane-0 source is the producer vector while feeding, zeros otherwise.
    assign src_x = feed_src ? x_row : '0;
    assign src_w = feed_src ? w_col : '0;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign arr_start = start_pend;

    // Next-state and handshake outputs for the job sequencer.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        arr_valid = 1'b0;
        feed_src  = 1'b0;
        case (state)
            IDLE: begin
                if (accept_start) begin
                    state_nxt = (k_clamped == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                in_ready  = !arr_stall;
                arr_valid = in_valid;
                feed_src  = 1'b1;
                if (in_valid && !arr_stall && (beat_cnt == k_lat - KW'(1))) begin
                    state_nxt = (FLUSH_LEN == 0) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                arr_valid = 1'b1;
                if (!arr_stall && (flush_cnt == FW'(FLUSH_LEN - 1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, job length latch, beat/flush counters and arr_start pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            k_lat      <= '0;
            beat_cnt   <= '0;
            flush_cnt  <= '0;
            start_pend <= 1'b0;
            armed      <= 1'b0;
        end else begin
            armed      <= 1'b1;
            state      <= state_nxt;
            start_pend <= accept_start;
            if (accept_start) begin
                k_lat     <= k_clamped;
                beat_cnt  <= '0;
                flush_cnt <= '0;
            end else if (advance) begin
                if (state == FEED) begin
                    beat_cnt <= beat_cnt + KW'(1);
                end
                if (state == FLUSH) begin
                    flush_cnt <= flush_cnt + FW'(1);
                end
            end
        end
    end

    // Lane 0 has no delay.
    assign arr_x[0 +: DATA_W] = src_x[0 +: DATA_W];
    assign arr_w[0 +: DATA_W] = src_w[0 +: DATA_W];

    for (genvar j = 1; j < N; j++) begin : g_lane
        logic [DATA_W-1:0] cx [0:j-1];
        logic [DATA_W-1:0] cw [0:j-1];

        // j-deep delay chain for lane j, cleared at job start so each job is
        // framed by zero padding.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                for (int i = 0; i < j; i++) begin
                    cx[i] <= '0;
                    cw[i] <= '0;
                end
            end else if (accept_start) begin
                for (int i = 0; i < j; i++) begin
                    cx[i] <= '0;
                    cw[i] <= '0;
                end
            end else if (advance) begin
                cx[0] <= src_x[j*DATA_W +: DATA_W];
                cw[0] <= src_w[j*DATA_W +: DATA_W];
                for (int i = 1; i < j; i++) begin
                    cx[i] <= cx[i-1];
                    cw[i] <= cw[i-1];
                end
            end
        end

        assign arr_x[j*DATA_W +: DATA_W] = cx[j-1];
        assign arr_w[j*DATA_W +: DATA_W] = cw[j-1];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: table of jobs with hand-computed
// advance counts and completion latency, an independent skew model for the
// vector contents, plus hand-written reset/abort sequences.
module tb_systolic_feeder;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int KMAX = 256;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int VW   = N * DW;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] x_row;
    logic [VW-1:0] w_col;
    logic          arr_start;
    logic          arr_valid;
    logic [VW-1:0] arr_x;
    logic [VW-1:0] arr_w;
    logic          arr_stall;
    logic          busy;
    logic          done;

    int compared   = 0;
    int mismatched = 0;

    systolic_feeder #(
        .N(N), .DATA_W(DW), .KMAX(KMAX), .PIPE_EXTRA(3)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .x_row(x_row), .w_col(w_col),
        .arr_start(arr_start), .arr_valid(arr_valid), .arr_x(arr_x), .arr_w(arr_w),
        .arr_stall(arr_stall), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int k_len;
        bit bubbles;
        int stall_at;
        int stall_len;
        bit hold_start;
        int exp_adv;
        int exp_beats;
        int exp_done;
    } job_t;

    job_t jobs [6];

    function automatic logic [VW-1:0] beat_vec(int b, bit is_w);
        logic [VW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) begin
            v[j*DW +: DW] = (is_w ? 32'hA000_0000 : 32'h0) | 32'(b * 16 + j);
        end
        return v;
    endfunction

    // Lane j at advance a carries element (a - j) of the job, zero outside it.
    function automatic logic [VW-1:0] model_vec(int a, int k, bit is_w);
        logic [VW-1:0] v;
        logic [VW-1:0] bv;
        int b;
        v = '0;
        for (int j = 0; j < N; j++) begin
            b = a - j;
            if (b >= 0 && b < k) begin
                bv = beat_vec(b, is_w);
                v[j*DW +: DW] = bv[j*DW +: DW];
            end
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [VW-1:0] act,
                               input logic [VW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, VW'(in_ready), '0);
        checkOutput({tag, "_arr_start"}, VW'(arr_start), '0);
        checkOutput({tag, "_arr_valid"}, VW'(arr_valid), '0);
        checkOutput({tag, "_arr_x"}, arr_x, '0);
        checkOutput({tag, "_arr_w"}, arr_w, '0);
        checkOutput({tag, "_busy"}, VW'(busy), '0);
        checkOutput({tag, "_done"}, VW'(done), '0);
    endtask

    // Runs one job from the start cycle (offset 0) to the done cycle, then
    // leaves the bench one cycle after done, in IDLE.
    task automatic applyStimulus(input int id, input job_t jb);
        int  keff;
        int  adv;
        int  bi;
        int  stalled;
        int  done_off;
        int  last_adv_off;
        int  starts;
        int  start_off;
        bit  fin;
        bit  feed;
        keff = (jb.k_len > KMAX) ? KMAX : jb.k_len;
        adv = 0; bi = 0; stalled = 0; done_off = -1; last_adv_off = -1;
        starts = 0; start_off = -1; fin = 1'b0;

        start = 1'b1; k_len = KW'(jb.k_len);
        in_valid = 1'b0; arr_stall = 1'b0; x_row = '0; w_col = '0;
        @(negedge clk);
        checkOutput($sformatf("job%0d_idle_busy", id), VW'(busy), '0);
        @(posedge clk); #1;
        if (!jb.hold_start) start = 1'b0;

        for (int off = 1; off <= 600 && !fin; off++) begin
            feed      = (bi < keff);
            in_valid  = feed && (!jb.bubbles || ((off - 1) % 2 == 0));
            x_row     = feed ? beat_vec(bi, 1'b0) : '0;
            w_col     = feed ? beat_vec(bi, 1'b1) : '0;
            arr_stall = (jb.stall_len > 0) && (adv == jb.stall_at) &&
                        (stalled < jb.stall_len);
            @(negedge clk);
            if (arr_start) begin
                starts++;
                start_off = off;
            end
            if (feed) begin
                checkOutput($sformatf("job%0d_valid_mirror_off%0d", id, off),
                            VW'(arr_valid), VW'(in_valid));
            end
            if (arr_stall) begin
                stalled++;
                checkOutput($sformatf("job%0d_stall_x_off%0d", id, off), arr_x, model_vec(adv, keff, 1'b0));
                checkOutput($sformatf("job%0d_stall_w_off%0d", id, off), arr_w, model_vec(adv, keff, 1'b1));
                checkOutput($sformatf("job%0d_stall_valid_off%0d", id, off), VW'(arr_valid), VW'(1));
                checkOutput($sformatf("job%0d_stall_ready_off%0d", id, off), VW'(in_ready), '0);
            end
            if (arr_valid && !arr_stall) begin
                checkOutput($sformatf("job%0d_x_adv%0d", id, adv), arr_x, model_vec(adv, keff, 1'b0));
                checkOutput($sformatf("job%0d_w_adv%0d", id, adv), arr_w, model_vec(adv, keff, 1'b1));
                adv++;
                last_adv_off = off;
            end
            if (in_valid && in_ready) bi++;
            if (done) begin
                done_off = off;
                fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; arr_stall = 1'b0; x_row = '0; w_col = '0;

        if (!fin) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL job%0d_timeout: got no done, expected done by offset %0d", id, jb.exp_done);
        end
        checkOutput($sformatf("job%0d_advances", id), VW'(adv), VW'(jb.exp_adv));
        checkOutput($sformatf("job%0d_beats", id), VW'(bi), VW'(jb.exp_beats));
        checkOutput($sformatf("job%0d_done_offset", id), VW'(done_off), VW'(jb.exp_done));
        checkOutput($sformatf("job%0d_arr_start_count", id), VW'(starts), VW'(1));
        checkOutput($sformatf("job%0d_arr_start_offset", id), VW'(start_off), VW'(1));
        if (jb.exp_adv > 0) begin
            checkOutput($sformatf("job%0d_done_after_last_adv", id),
                        VW'(done_off), VW'(last_adv_off + 1));
        end

        if (jb.hold_start) begin
            // start still high: IDLE must be visible for one cycle, then a
            // zero-length job runs and completes in the following cycle.
            k_len = '0;
            @(negedge clk);
            checkOutput($sformatf("job%0d_hold_idle_busy", id), VW'(busy), '0);
            checkOutput($sformatf("job%0d_hold_idle_done", id), VW'(done), '0);
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("job%0d_hold_next_busy", id), VW'(busy), VW'(1));
            checkOutput($sformatf("job%0d_hold_next_done", id), VW'(done), VW'(1));
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput($sformatf("job%0d_hold_back_idle", id), VW'(busy), '0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int adv;
        int bi;
        job_t rj;

        //        k    bub  sat slen hold adv  beats done
        jobs[0] = '{8,   0,  0,  0,  0,  14,  8,   15};
        jobs[1] = '{8,   0,  5,  3,  0,  14,  8,   18};
        jobs[2] = '{4,   1,  0,  0,  0,  10,  4,   14};
        jobs[3] = '{0,   0,  0,  0,  0,  0,   0,   1};
        jobs[4] = '{300, 0,  0,  0,  0,  262, 256, 263};
        jobs[5] = '{3,   0,  0,  0,  1,  9,   3,   10};

        n_rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        x_row = '0; w_col = '0; arr_stall = 1'b0;
        #3 n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");

        // Release reset with start already high: that start must be ignored.
        n_rst = 1'b1; start = 1'b1; k_len = KW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("start_at_release_ignored", VW'(busy), '0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(i, jobs[i]);
        end

        // Abort a job in the middle of its flush with an asynchronous reset.
        start = 1'b1; k_len = KW'(8);
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        adv = 0; bi = 0;
        for (int c = 0; c < 100 && adv < 10; c++) begin
            in_valid = (bi < 8);
            x_row = (bi < 8) ? beat_vec(bi, 1'b0) : '0;
            w_col = (bi < 8) ? beat_vec(bi, 1'b1) : '0;
            @(negedge clk);
            if (arr_valid && !arr_stall) adv++;
            if (in_valid && in_ready) bi++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; x_row = '0; w_col = '0;
        checkOutput("abort_reached_flush_adv2", VW'(adv), VW'(10));
        checkOutput("abort_pre_valid", VW'(arr_valid), VW'(1));
        checkOutput("abort_pre_busy", VW'(busy), VW'(1));
        #1 n_rst = 1'b0;
        #1 checkAllZero("abort");
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort_no_done", VW'(done), '0);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        rj = '{2, 0, 0, 0, 0, 8, 2, 9};
        applyStimulus(6, rj);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
